// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding and the grant-index width rule.
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 65535;

    // grant_id is never narrower than one bit, even with two requesters
    function automatic int arb_id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and serializer-side byte streams of the UART transmit arbiter.
// The arbiter uses the slave view; whoever drives the requesters uses the master view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_evt;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, busy, grant_id, timeout_evt
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, busy, grant_id, timeout_evt
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping around the requester count.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = arb_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);
    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      sum;

    always_comb begin
        // rotate so bit 0 is the requester rr_ptr points at
        rot     = NUM_REQ'({req, req} >> rr_ptr);
        offset  = '0;
        any_req = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        pick = sum[ID_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART serializer byte input
// between several requesters, with an optional idle timeout on the holder.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | no grant held; outputs quiet; pick next requester if any
// ARB_LOCKED | grant_id owns the serializer until a last byte or a timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 1,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input logic              core_clk,
    input logic              core_rstn,
    uart_tx_arbiter_if.slave bus
);
    localparam bit              TO_EN    = (TIMEOUT_CYC > 0);
    localparam int              CNT_W    = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_nx;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  pick;
    logic [CNT_W-1:0] idle_cnt;
    logic             any_req;
    logic             timeout_evt;
    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_data;
    logic             handshake;
    logic             fire;
    logic             release_grant;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        rr_nx         = rr_ptr;
        handshake     = 1'b0;
        fire          = 1'b0;
        release_grant = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.req_ready = '0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nx = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                bus.tx_valid = g_valid;
                bus.tx_data  = g_valid ? g_data : 8'h00;
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.req_ready[i] = (grant_id == ID_W'(i)) && bus.tx_ready;
                end
                handshake = g_valid && bus.tx_ready;
                // a timeout needs req_valid low, so it never coincides with a last handshake
                fire          = TO_EN && !g_valid && (idle_cnt == CNT_LAST);
                release_grant = (handshake && g_last) || fire;
                if (release_grant) begin
                    state_nx = ARB_IDLE;
                    rr_nx    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_nx;
            timeout_evt <= fire;
            if (state == ARB_IDLE) begin
                if (any_req) begin
                    grant_id <= pick;
                    idle_cnt <= '0;
                end
            end else if (TO_EN) begin
                // a stalled serializer with valid data holds the count
                if (handshake) begin
                    idle_cnt <= '0;
                end else if (!g_valid && (idle_cnt != '1)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy        = (state == ARB_LOCKED);
    assign bus.grant_id    = grant_id;
    assign bus.timeout_evt = timeout_evt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: three requesters, 16-cycle idle timeout.
// Expected bytes are queued when stimulus is queued and popped at each serializer handoff.
module tb_uart_tx_arbiter;
    localparam int NR = 3;
    localparam int IW = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .ID_W        (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .core_clk  (clk),
        .core_rstn (rst_n),
        .bus       (bus)
    );

    exp_t       exp_q[$];
    logic [8:0] sq[NR][$];
    logic [NR-1:0] hs = '0;
    logic rdy_req = 1'b1;
    int checks = 0;
    int errors = 0;
    int to_seen = 0;

    // one clock: apply inputs just after the edge, observe and score at the falling edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        bus.tx_ready = rdy_req;
        for (int r = 0; r < NR; r++) begin
            if (hs[r] && sq[r].size() > 0) void'(sq[r].pop_front());
            if (sq[r].size() > 0) begin
                bus.req_valid[r]        = 1'b1;
                bus.req_data[8*r +: 8]  = sq[r][0][7:0];
                bus.req_last[r]         = sq[r][0][8];
            end else begin
                bus.req_valid[r]        = 1'b0;
                bus.req_data[8*r +: 8]  = 8'h00;
                bus.req_last[r]         = 1'b0;
            end
        end
        @(negedge clk);
        for (int r = 0; r < NR; r++) hs[r] = bus.req_valid[r] && bus.req_ready[r];
        if (bus.timeout_evt) to_seen++;
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got id=%0d data=%02h, want no byte", bus.grant_id, bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e.data || bus.grant_id !== e.id) begin
                    errors++;
                    $display("FAIL scoreboard: got id=%0d data=%02h, want id=%0d data=%02h",
                             bus.grant_id, bus.tx_data, e.id, e.data);
                end
            end
        end
    endtask

    function automatic bit stim_pending();
        for (int r = 0; r < NR; r++) if (sq[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || stim_pending() || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL drain: %0d bytes still expected, busy=%0b, want 0 and 0", exp_q.size(), bus.busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0b tx_valid=%0b timeout_evt=%0b, want 0 0 0",
                     bus.busy, bus.tx_valid, bus.timeout_evt);
        end
        checks++;
        if (bus.req_ready !== 3'b000 || bus.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: req_ready=%b tx_data=%02h, want 000 00", bus.req_ready, bus.tx_data);
        end
        checks++;
        if (bus.grant_id !== 2'd0 || dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: grant_id=%0d rr_ptr=%0d, want 0 0", bus.grant_id, dut.rr_ptr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        sq[0].push_back({1'b0, 8'h48});
        sq[0].push_back({1'b1, 8'h69});
        exp_q.push_back('{id: 2'd0, data: 8'h48});
        exp_q.push_back('{id: 2'd0, data: 8'h69});
        repeat (10) begin
            tick();
            if (bus.busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 2) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d, want 2", busy_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL single_done: pending=%0d rr_ptr=%0d, want 0 1", exp_q.size(), dut.rr_ptr);
        end
    endtask

    task automatic test_contention();
        for (int b = 0; b < 3; b++) begin
            sq[0].push_back({(b == 2), 8'hC0 + 8'(b)});
            sq[1].push_back({(b == 2), 8'hD0 + 8'(b)});
        end
        for (int b = 0; b < 3; b++) exp_q.push_back('{id: 2'd0, data: 8'hC0 + 8'(b)});
        for (int b = 0; b < 3; b++) exp_q.push_back('{id: 2'd1, data: 8'hD0 + 8'(b)});
        wait_drain(40);
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL contention_rr_ptr: got %0d, want 2", dut.rr_ptr);
        end
    endtask

    task automatic test_round_robin();
        int busy_cnt = 0;
        int first = -1;
        int last = -1;
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < NR; r++) begin
                sq[r].push_back({1'b1, 8'(8'h10 * (r + 1) + m)});
                exp_q.push_back('{id: IW'(r), data: 8'(8'h10 * (r + 1) + m)});
            end
        for (int t = 0; t < 40; t++) begin
            tick();
            if (bus.busy) begin
                busy_cnt++;
                if (first < 0) first = t;
                last = t;
            end
            if (exp_q.size() == 0 && !bus.busy && busy_cnt > 0) break;
        end
        checks++;
        if (busy_cnt != 6) begin
            errors++;
            $display("FAIL rr_busy_cycles: got %0d, want 6", busy_cnt);
        end
        // six one-cycle grants separated by single idle cycles
        checks++;
        if (last - first != 10) begin
            errors++;
            $display("FAIL rr_span: got %0d cycles, want 10", last - first);
        end
        wait_drain(10);
    endtask

    task automatic test_backpressure();
        rdy_req = 1'b0;
        tick();
        to_seen = 0;
        sq[0].push_back({1'b1, 8'hA5});
        exp_q.push_back('{id: 2'd0, data: 8'hA5});
        repeat (20) tick();
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5 || bus.req_ready !== 3'b000) begin
            errors++;
            $display("FAIL bp_stall: tx_valid=%0b tx_data=%02h req_ready=%b, want 1 a5 000",
                     bus.tx_valid, bus.tx_data, bus.req_ready);
        end
        checks++;
        if (to_seen != 0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_timeout: pulses=%0d busy=%0b, want 0 1", to_seen, bus.busy);
        end
        rdy_req = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        int n = 0;
        to_seen = 0;
        sq[1].push_back({1'b0, 8'h11});
        sq[0].push_back({1'b1, 8'h22});
        exp_q.push_back('{id: 2'd1, data: 8'h11});
        exp_q.push_back('{id: 2'd0, data: 8'h22});
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.tx_valid && bus.tx_ready && bus.grant_id == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL timeout_first_byte: req1 byte not handed off, want handoff");
        end
        while (!bus.timeout_evt && n < 40) begin
            tick();
            n++;
        end
        // req_valid drops in the cycle after the handoff; the pulse shows 16 cycles later
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL timeout_delay: pulse %0d cycles after handoff, want 17", n);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%0b, want 0", bus.busy);
        end
        tick();
        checks++;
        if (bus.timeout_evt !== 1'b0 || bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: evt=%0b grant_id=%0d busy=%0b, want 0 0 1",
                     bus.timeout_evt, bus.grant_id, bus.busy);
        end
        wait_drain(20);
        checks++;
        if (to_seen != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, want 1", to_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        sq[0].push_back({1'b0, 8'h33});
        sq[0].push_back({1'b1, 8'h44});
        exp_q.push_back('{id: 2'd0, data: 8'h33});
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.tx_valid && bus.tx_ready && bus.tx_data == 8'h33) begin
                found = 1'b1;
                break;
            end
        end
        rdy_req = 1'b0;
        tick();
        checks++;
        if (!found || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h44) begin
            errors++;
            $display("FAIL mid_second_byte: found=%0b tx_valid=%0b tx_data=%02h, want 1 1 44",
                     found, bus.tx_valid, bus.tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000 || bus.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_async_reset: tx_valid=%0b busy=%0b req_ready=%b tx_data=%02h, want 0 0 000 00",
                     bus.tx_valid, bus.busy, bus.req_ready, bus.tx_data);
        end
        for (int r = 0; r < NR; r++) sq[r].delete();
        tick();
        tick();
        checks++;
        if (dut.rr_ptr !== 2'd0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_ptr: rr_ptr=%0d grant_id=%0d, want 0 0", dut.rr_ptr, bus.grant_id);
        end
        rst_n = 1'b1;
        rdy_req = 1'b1;
        sq[1].push_back({1'b1, 8'h55});
        exp_q.push_back('{id: 2'd1, data: 8'h55});
        wait_drain(20);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
        test_reset();
        test_single();
        do_reset();
        test_contention();
        do_reset();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
